// File: rtl/uart_apb_pkg.sv
// Register map, bit positions and threshold helper shared by the UART RX APB read block.
package uart_apb_pkg;

    localparam logic [31:0] RXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] CTRL_OFS   = 32'h0000_0008;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_RX_BUSY   = 3;
    localparam int ST_LEVEL_LSB = 8;

    localparam int CTRL_IRQ_EN   = 0;
    localparam int CTRL_FLUSH    = 1;
    localparam int CTRL_THR_LSB  = 8;

    // A zero threshold behaves as one; anything beyond the FIFO depth saturates.
    function automatic logic [8:0] thr_effective(input logic [7:0] thr, input logic [8:0] depth);
        logic [8:0] t;
        t = {1'b0, thr};
        if (t == 9'd0) begin
            t = 9'd1;
        end else if (t > depth) begin
            t = depth;
        end else begin
            t = t;
        end
        return t;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; a push is accepted when full if a pop coincides.
module uart_rx_fifo
    import uart_apb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wptr_r;
    logic [AW-1:0]         rptr_r;
    logic [LW-1:0]         level_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  pop_ok_s;
    logic                  push_ok_s;

    // Occupancy flags and accepted push/pop qualifiers.
    always_comb begin
        empty_s   = (level_r == {LW{1'b0}});
        full_s    = (level_r == LW'(FIFO_DEPTH));
        pop_ok_s  = pop & ~empty_s;
        push_ok_s = push & (~full_s | pop_ok_s);
        full      = full_s;
        empty     = empty_s;
        level     = level_r;
        dout      = mem_r[rptr_r];
    end

    // Pointer and level update; flush discards everything including a coincident push.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            level_r <= {LW{1'b0}};
        end else if (flush) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            level_r <= {LW{1'b0}};
        end else begin
            if (push_ok_s) wptr_r <= wptr_r + AW'(1);
            if (pop_ok_s)  rptr_r <= rptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {DATA_WIDTH{1'b0}};
        end else if (push_ok_s & ~flush) begin
            mem_r[wptr_r] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_apb_read.sv
// APB3 register front-end for the UART receiver: RX FIFO, sticky overrun, CTRL.
// Optional level interrupt with threshold is built only when UART_RX_IRQ_EN is defined.
module uart_rx_apb_read
    import uart_apb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_done_i,
    input  logic                  rx_busy_i,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr
`ifdef UART_RX_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]           addr_s;
    logic                  access_s;
    logic                  rd_s;
    logic                  wr_s;
    logic                  sel_rx_s;
    logic                  sel_st_s;
    logic                  sel_ctrl_s;
    logic                  fifo_pop_s;
    logic                  flush_s;
    logic                  ovr_set_s;
    logic                  ovr_clr_s;
    logic                  unused_s;
    logic [DATA_WIDTH-1:0] fifo_dout_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [LW-1:0]         fifo_level_s;
    logic                  overrun_r;
    logic [31:0]           status_s;
    logic [31:0]           ctrl_rd_s;
`ifdef UART_RX_IRQ_EN
    logic                  irq_en_r;
    logic [7:0]            thr_r;
    logic                  irq_r;
`endif

    // Address decode and the qualified side effects of the current access phase.
    always_comb begin
        addr_s     = {{(32-ADDR_WIDTH){1'b0}}, paddr[ADDR_WIDTH-1:2], 2'b00};
        access_s   = psel & penable;
        rd_s       = access_s & ~pwrite;
        wr_s       = access_s & pwrite;
        sel_rx_s   = (addr_s == RXDATA_OFS);
        sel_st_s   = (addr_s == STATUS_OFS);
        sel_ctrl_s = (addr_s == CTRL_OFS);
        fifo_pop_s = rd_s & sel_rx_s & ~fifo_empty_s;
        flush_s    = wr_s & sel_ctrl_s & pwdata[CTRL_FLUSH];
        // A push dropped by flush is discarded on purpose, so it never counts as overrun.
        ovr_set_s  = rx_done_i & fifo_full_s & ~fifo_pop_s & ~flush_s;
        ovr_clr_s  = wr_s & sel_st_s & pwdata[ST_OVERRUN];
        unused_s   = ^{pwdata, paddr[1:0]};
        pready     = 1'b1;
    end

    uart_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rx_done_i),
        .pop   (fifo_pop_s),
        .flush (flush_s),
        .din   (rx_data_i),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Sticky overrun; a new overrun in the same cycle beats the W1C clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun_r <= 1'b0;
        end else if (ovr_set_s) begin
            overrun_r <= 1'b1;
        end else if (ovr_clr_s) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

`ifdef UART_RX_IRQ_EN
    // CTRL enable/threshold fields; flush is a pulse and is not stored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_en_r <= 1'b0;
            thr_r    <= 8'h00;
        end else if (wr_s & sel_ctrl_s) begin
            irq_en_r <= pwdata[CTRL_IRQ_EN];
            thr_r    <= pwdata[CTRL_THR_LSB +: 8];
        end else begin
            irq_en_r <= irq_en_r;
            thr_r    <= thr_r;
        end
    end

    // Registered level interrupt.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_en_r &
                     ((9'(fifo_level_s) >= thr_effective(thr_r, 9'(FIFO_DEPTH))) | overrun_r);
        end
    end

    // Interrupt output.
    always_comb begin
        irq = irq_r;
    end
`endif

    // STATUS and CTRL read views.
    always_comb begin
        status_s                       = 32'h0000_0000;
        status_s[ST_NOT_EMPTY]         = ~fifo_empty_s;
        status_s[ST_FULL]              = fifo_full_s;
        status_s[ST_OVERRUN]           = overrun_r;
        status_s[ST_RX_BUSY]           = rx_busy_i;
        status_s[ST_LEVEL_LSB +: 8]    = 8'(fifo_level_s);
        ctrl_rd_s                      = 32'h0000_0000;
`ifdef UART_RX_IRQ_EN
        ctrl_rd_s[CTRL_IRQ_EN]         = irq_en_r;
        ctrl_rd_s[CTRL_THR_LSB +: 8]   = thr_r;
`endif
    end

    // APB response: driven only during the access phase.
    always_comb begin
        prdata  = 32'h0000_0000;
        pslverr = 1'b0;
        if (access_s) begin
            case (addr_s)
                RXDATA_OFS: begin
                    if (pwrite | fifo_empty_s) begin
                        pslverr = 1'b1;
                    end else begin
                        prdata = 32'(fifo_dout_s);
                    end
                end
                STATUS_OFS: begin
                    if (!pwrite) prdata = status_s;
                    else         prdata = 32'h0000_0000;
                end
                CTRL_OFS: begin
                    if (!pwrite) prdata = ctrl_rd_s;
                    else         prdata = 32'h0000_0000;
                end
                default: begin
                    pslverr = 1'b1;
                end
            endcase
        end else begin
            prdata  = 32'h0000_0000;
            pslverr = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_apb_read.sv
// Self-checking bench for uart_rx_apb_read: directed scenarios plus randomized traffic
// against a queue-based model of the register block (irq checks when UART_RX_IRQ_EN is defined).
module tb_uart_rx_apb_read;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] rx_data_i;
    logic          rx_done_i;
    logic          rx_busy_i;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready, pslverr;
`ifdef UART_RX_IRQ_EN
    logic          irq;
`endif

    always #5 clk = ~clk;

    uart_rx_apb_read #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
        .rx_busy_i(rx_busy_i), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
`ifdef UART_RX_IRQ_EN
        , .irq(irq)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: byte queue, sticky overrun, CTRL fields.
    logic [7:0] model_q[$];
    logic       model_ovr    = 1'b0;
    logic       model_irq_en = 1'b0;
    logic [7:0] model_thr    = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s       = 32'h0;
        s[0]    = (model_q.size() != 0);
        s[1]    = (model_q.size() == DEPTH);
        s[2]    = model_ovr;
        s[3]    = rx_busy_i;
        s[15:8] = 8'(model_q.size());
        return s;
    endfunction

    function automatic logic [31:0] exp_ctrl();
`ifdef UART_RX_IRQ_EN
        return {16'h0, model_thr, 7'h0, model_irq_en};
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic exp_irq();
        int t;
        t = (model_thr == 8'd0) ? 1 : ((int'(model_thr) > DEPTH) ? DEPTH : int'(model_thr));
        return model_irq_en & ((model_q.size() >= t) | model_ovr);
    endfunction

    task automatic model_rx(input logic [7:0] b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovr = 1'b1;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data_i = b;
        rx_done_i = 1'b1;
        @(posedge clk); #1;
        rx_done_i = 1'b0;
        model_rx(b);
    endtask

    // One APB transfer, optionally with a receiver byte landing in the access cycle.
    task automatic apb(input string tag, input logic wr, input logic [3:0] addr,
                       input logic [31:0] wdata, input logic do_push, input logic [7:0] pbyte);
        logic [31:0] exp_rd;
        logic        exp_err, do_pop, do_flush, do_clr;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1; rx_done_i = do_push; rx_data_i = pbyte;
        exp_rd = 32'h0; exp_err = 1'b0; do_pop = 1'b0; do_flush = 1'b0; do_clr = 1'b0;
        case (addr[3:2])
            2'd0: begin
                if (wr || model_q.size() == 0) exp_err = 1'b1;
                else begin exp_rd = {24'h0, model_q[0]}; do_pop = 1'b1; end
            end
            2'd1: if (wr) do_clr = wdata[2]; else exp_rd = exp_status();
            2'd2: if (wr) do_flush = wdata[1]; else exp_rd = exp_ctrl();
            default: exp_err = 1'b1;
        endcase
        @(negedge clk);
        check_eq({tag, ".prdata"}, prdata, exp_rd);
        check_eq({tag, ".pslverr"}, 32'(pslverr), 32'(exp_err));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; rx_done_i = 1'b0;
        if (do_pop) void'(model_q.pop_front());
        if (do_clr) model_ovr = 1'b0;
`ifdef UART_RX_IRQ_EN
        if (wr && addr[3:2] == 2'd2) begin model_irq_en = wdata[0]; model_thr = wdata[15:8]; end
`endif
        if (do_flush) model_q.delete();
        else if (do_push) model_rx(pbyte);
    endtask

    initial begin
        int unsigned sel;
        logic [7:0]  b;
        logic        cp;
        logic [1:0]  lo;
        logic [31:0] w;

        rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
        pwdata = 32'h0; rx_data_i = 8'h00; rx_done_i = 1'b0; rx_busy_i = 1'b0;
        #2;
        check_eq("rst.prdata", prdata, 32'h0);
        check_eq("rst.pslverr", 32'(pslverr), 32'h0);
        check_eq("rst.pready", 32'(pready), 32'h1);
`ifdef UART_RX_IRQ_EN
        check_eq("rst.irq", 32'(irq), 32'h0);
`endif
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        apb("rst_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h00);
        apb("rst_ctrl", 1'b0, 4'h8, 32'h0, 1'b0, 8'h00);

        // Two bytes out in order, then an empty read errors.
        push(8'h55); push(8'hA3);
        apb("rd1", 1'b0, 4'h0, 32'h0, 1'b0, 8'h00);
        apb("rd2", 1'b0, 4'h0, 32'h0, 1'b0, 8'h00);
        apb("rd_empty", 1'b0, 4'h0, 32'h0, 1'b0, 8'h00);

        // Seventeen pushes: full plus overrun, then W1C clear.
        for (int i = 0; i < 17; i++) push(8'(i + 8'h10));
        apb("ovr_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h00);
        apb("ovr_clr", 1'b1, 4'h4, 32'h4, 1'b0, 8'h00);
        apb("ovr_status2", 1'b0, 4'h4, 32'h0, 1'b0, 8'h00);

        // Full FIFO: pop and push in the same cycle, then drain.
        apb("full_poppush", 1'b0, 4'h0, 32'h0, 1'b1, 8'hEE);
        apb("full_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) apb("drain", 1'b0, 4'h0, 32'h0, 1'b0, 8'h00);
        apb("drain_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h00);

        // Empty FIFO: a pop attempt and a push together; the push lands.
        apb("empty_poppush", 1'b0, 4'h0, 32'h0, 1'b1, 8'h3C);
        apb("empty_pp_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h00);

        // Flush with a coincident push while overrun is set.
        for (int i = 0; i < 17; i++) push(8'(i));
        apb("flush_push", 1'b1, 4'h8, 32'h2, 1'b1, 8'h77);
        apb("flush_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h00);
        apb("flush_rd", 1'b0, 4'h0, 32'h0, 1'b0, 8'h00);
        apb("flush_ctrl", 1'b0, 4'h8, 32'h0, 1'b0, 8'h00);
        apb("bad_wr_rx", 1'b1, 4'h0, 32'hFF, 1'b0, 8'h00);
        apb("ovr_clr3", 1'b1, 4'h4, 32'h4, 1'b0, 8'h00);

`ifdef UART_RX_IRQ_EN
        apb("irq_cfg", 1'b1, 4'h8, 32'h0301, 1'b0, 8'h00);
        push(8'h01); push(8'h02); push(8'h03);
        check_eq("irq_before", 32'(irq), 32'h0);
        idle();
        check_eq("irq_after3", 32'(irq), 32'h1);
        apb("irq_pop", 1'b0, 4'h0, 32'h0, 1'b0, 8'h00);
        idle();
        check_eq("irq_afterpop", 32'(irq), 32'h0);
        apb("irq_off", 1'b1, 4'h8, 32'h0002, 1'b0, 8'h00);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            b   = 8'($urandom);
            cp  = ($urandom_range(0, 2) == 0);
            lo  = 2'($urandom);
            w   = $urandom;
            rx_busy_i = 1'($urandom);
            case (sel)
                0, 1, 2: push(b);
                3, 4, 5: apb("rnd_rx", 1'b0, {2'd0, lo}, w, cp, b);
                6:       apb("rnd_st_rd", 1'b0, {2'd1, lo}, w, cp, b);
                7:       apb("rnd_st_wr", 1'b1, {2'd1, lo}, w, cp, b);
                8: begin
                    if ($urandom_range(0, 7) != 0) w[1] = 1'b0;
                    apb("rnd_ctrl_wr", 1'b1, {2'd2, lo}, w, cp, b);
                end
                default: begin
                    if (w[31]) w[1] = 1'b0;
                    apb("rnd_misc", 1'($urandom), {2'($urandom), lo}, w, cp, b);
                end
            endcase
`ifdef UART_RX_IRQ_EN
            if (sel >= 6) begin
                idle();
                check_eq("rnd_irq", 32'(irq), 32'(exp_irq()));
            end
`endif
        end

        // Reset in the middle of an access phase with five entries held.
        rx_busy_i = 1'b0;
        apb("pre_rst_flush", 1'b1, 4'h8, 32'h2, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        rstn = 1'b0; psel = 1'b0; penable = 1'b0;
        #1;
        check_eq("midrst.prdata", prdata, 32'h0);
        check_eq("midrst.pslverr", 32'(pslverr), 32'h0);
        check_eq("midrst.pready", 32'(pready), 32'h1);
`ifdef UART_RX_IRQ_EN
        check_eq("midrst.irq", 32'(irq), 32'h0);
`endif
        model_q.delete(); model_ovr = 1'b0; model_irq_en = 1'b0; model_thr = 8'h00;
        @(posedge clk); #1 rstn = 1'b1;
        apb("postrst_status", 1'b0, 4'h4, 32'h0, 1'b0, 8'h00);
        apb("postrst_unmapped", 1'b0, 4'hC, 32'h0, 1'b0, 8'h00);
        apb("postrst_unmapped_wr", 1'b1, 4'hC, 32'h2, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
